pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; one port per line below: name, direction, width, meaning.
REQ-002 pci_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 pci_rst  in  1  reset, synchronous, active-high.
REQ-004 pci_id_rs1 / pci_id_rs2  in  4 each  ID-stage source registers; `REG_INVALID means unused.
REQ-005 pci_exe_wreg_addr  in  4  EXE-stage destination register, from the ID/EXE register output.
REQ-006 pci_exe_rwe  in  2  EXE-stage memory op: RWE_IDLE, RWE_READ or RWE_WRITE.
REQ-007 pci_exe_branch  in  1  EXE-stage branch resolved taken.
REQ-008 pci_mem_rwe  in  2  MEM-stage memory op; any non-IDLE value occupies the shared instruction/data RAM.
REQ-009 pco_pc_en  out  1  PC update enable.
REQ-010 pco_pc_sel  out  1  0 = PC+1, 1 = branch target.
REQ-011 pco_if_id_en  out  1  IF/ID load enable (0 = hold).
REQ-012 pco_if_id_flush  out  1  IF/ID loads a NOP.
REQ-013 pco_id_exe_en  out  1  ID/EXE enable; 0 inserts a bubble, because ID/EXE clears itself when disabled.
REQ-014 pco_stall_cnt / pco_flush_cnt / pco_struct_cnt  out  16 each  performance counters (see Configuration).

Function
REQ-015 FSM states: RUN, LU_STALL, BR_FLUSH, ST_STALL; state is registered, and outputs are decoded combinationally from state plus the current inputs.
REQ-016 Load-use hazard (lu) SHALL be asserted when all hold:
- pci_exe_rwe==RWE_READ;
- pci_exe_wreg_addr != `REG_INVALID;
- pci_exe_wreg_addr equals a valid pci_id_rs1 or pci_id_rs2.
REQ-017 Structural hazard (st) SHALL be asserted when pci_mem_rwe != RWE_IDLE.
REQ-018 Priority SHALL be branch > st > lu; a lower-priority event in the same cycle is discarded, never queued.
REQ-019 Branch cycle outputs: pc_en=1, pc_sel=1, if_id_flush=1, id_exe_en=0; next state BR_FLUSH.
REQ-020 st cycle (no branch) outputs: pc_en=0, if_id_en=1, if_id_flush=1, id_exe_en=1; next state ST_STALL.
REQ-021 lu cycle (no branch, no st) outputs: pc_en=0, if_id_en=0, if_id_flush=0, id_exe_en=0; next state LU_STALL.
REQ-022 No-event cycle outputs: pc_en=1, pc_sel=0, if_id_en=1, if_id_flush=0, id_exe_en=1; next state RUN.
REQ-023 In LU_STALL, lu SHALL be ignored, since EXE holds the bubble; a load-use stall is therefore exactly 1 cycle.
REQ-024 Branch and st events SHALL still be honoured in LU_STALL.
REQ-025 BR_FLUSH and ST_STALL SHALL re-evaluate all events each cycle; back-to-back MEM accesses extend ST_STALL one cycle per access.
REQ-026 Hazard checks SHALL be pure 4-bit equality; register `REG_INVALID never matches.

Reset
REQ-027 While pci_rst=1: state=RUN; pc_en=0, pc_sel=0, if_id_en=0, if_id_flush=1, id_exe_en=0; counters=0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL abandon the stall or flush with no residual effect.
REQ-029 The first cycle after reset SHALL behave as RUN.

Configuration
REQ-030 Macro PIPE_CTRL_PERF_EN, when defined, enables the three counters:
- stall_cnt increments per lu cycle;
- flush_cnt increments per branch cycle;
- struct_cnt increments per st cycle;
- each counter saturates at 16'hFFFF.
REQ-031 When PIPE_CTRL_PERF_EN is undefined, the counter ports SHALL exist and be tied to 16'h0, with no counter flops.

Structure
REQ-032 RWE_IDLE, RWE_READ, RWE_WRITE and `REG_INVALID SHALL come from the shared defines.
REQ-033 The FSM state encodings SHALL be added to the shared defines as PC_ST_* constants.
REQ-034 One sub-module, pipe_ctrl_hazard, SHALL hold the combinational lu/st/branch detection; the FSM and counters stay in pipe_ctrl.

Verification
REQ-035 Load-use: exe_rwe=READ, exe_wreg=4'h3, id_rs1=4'h3 -> one cycle with pc_en=0, id_exe_en=0, then RUN even though the inputs stay unchanged.
REQ-036 Branch + lu in the same cycle: exe_branch=1 with a matching load -> pc_sel=1, if_id_flush=1, id_exe_en=0; stall_cnt unchanged and flush_cnt+1.
REQ-037 Structural: mem_rwe=WRITE for 3 consecutive cycles -> pc_en=0 and if_id_flush=1 for those 3 cycles; struct_cnt=3.
REQ-038 Invalid register: exe_wreg=`REG_INVALID=id_rs2, exe_rwe=READ -> no stall.
REQ-039 Reset mid-stall: assert pci_rst during LU_STALL -> reset outputs next edge, RUN after release, counters=0.
REQ-040 Saturation (PERF_EN): force 65536 lu events -> stall_cnt=16'hFFFF; without the macro all counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared pipeline-control definitions: memory-op codes, the
//               invalid-register marker and the PC_ST_* FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [1:0] RWE_IDLE  = 2'd0;
    localparam logic [1:0] RWE_READ  = 2'd1;
    localparam logic [1:0] RWE_WRITE = 2'd2;

    localparam logic [3:0] REG_INVALID = 4'hF;

    typedef enum logic [1:0] {
        PC_ST_RUN      = 2'd0,
        PC_ST_LU_STALL = 2'd1,
        PC_ST_BR_FLUSH = 2'd2,
        PC_ST_ST_STALL = 2'd3
    } pc_state_e;

    // Pure 4-bit equality; the invalid marker never matches anything.
    function automatic logic reg_match(input logic [3:0] a, input logic [3:0] b);
        return (a != REG_INVALID) && (b != REG_INVALID) && (a == b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hazard.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_hazard
// Description : Combinational detection of load-use, structural and branch
//               events; no priority or state masking is applied here.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] i_id_rs1,
    input  logic [3:0] i_id_rs2,
    input  logic [3:0] i_exe_wreg_addr,
    input  logic [1:0] i_exe_rwe,
    input  logic       i_exe_branch,
    input  logic [1:0] i_mem_rwe,
    output logic       o_lu,
    output logic       o_st,
    output logic       o_br
);

    assign o_lu = (i_exe_rwe == RWE_READ)
               && (reg_match(i_exe_wreg_addr, i_id_rs1)
                || reg_match(i_exe_wreg_addr, i_id_rs2));
    assign o_st = (i_mem_rwe != RWE_IDLE);
    assign o_br = i_exe_branch;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control FSM (RUN/LU_STALL/BR_FLUSH/ST_STALL) with
//               optional saturating performance counters (PIPE_CTRL_PERF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        pci_clk,
    input  logic        pci_rst,
    input  logic [3:0]  pci_id_rs1,
    input  logic [3:0]  pci_id_rs2,
    input  logic [3:0]  pci_exe_wreg_addr,
    input  logic [1:0]  pci_exe_rwe,
    input  logic        pci_exe_branch,
    input  logic [1:0]  pci_mem_rwe,
    output logic        pco_pc_en,
    output logic        pco_pc_sel,
    output logic        pco_if_id_en,
    output logic        pco_if_id_flush,
    output logic        pco_id_exe_en,
    output logic [15:0] pco_stall_cnt,
    output logic [15:0] pco_flush_cnt,
    output logic [15:0] pco_struct_cnt
);

    pc_state_e r_state;
    pc_state_e w_state_nxt;
    logic      w_lu_raw;
    logic      w_st_raw;
    logic      w_br_raw;
    logic      w_ev_br;
    logic      w_ev_st;
    logic      w_ev_lu;

    pipe_ctrl_hazard u_hazard (
        .i_id_rs1        (pci_id_rs1),
        .i_id_rs2        (pci_id_rs2),
        .i_exe_wreg_addr (pci_exe_wreg_addr),
        .i_exe_rwe       (pci_exe_rwe),
        .i_exe_branch    (pci_exe_branch),
        .i_mem_rwe       (pci_mem_rwe),
        .o_lu            (w_lu_raw),
        .o_st            (w_st_raw),
        .o_br            (w_br_raw)
    );

    // EXE already holds the bubble in LU_STALL, so a second lu is ignored.
    assign w_ev_br = !pci_rst && w_br_raw;
    assign w_ev_st = !pci_rst && !w_br_raw && w_st_raw;
    assign w_ev_lu = !pci_rst && !w_br_raw && !w_st_raw && w_lu_raw
                  && (r_state != PC_ST_LU_STALL);

    always_comb begin
        pco_pc_en       = 1'b1;
        pco_pc_sel      = 1'b0;
        pco_if_id_en    = 1'b1;
        pco_if_id_flush = 1'b0;
        pco_id_exe_en   = 1'b1;
        w_state_nxt     = PC_ST_RUN;
        if (pci_rst) begin
            pco_pc_en       = 1'b0;
            pco_if_id_en    = 1'b0;
            pco_if_id_flush = 1'b1;
            pco_id_exe_en   = 1'b0;
        end else if (w_ev_br) begin
            pco_pc_sel      = 1'b1;
            pco_if_id_flush = 1'b1;
            pco_id_exe_en   = 1'b0;
            w_state_nxt     = PC_ST_BR_FLUSH;
        end else if (w_ev_st) begin
            pco_pc_en       = 1'b0;
            pco_if_id_flush = 1'b1;
            w_state_nxt     = PC_ST_ST_STALL;
        end else if (w_ev_lu) begin
            pco_pc_en       = 1'b0;
            pco_if_id_en    = 1'b0;
            pco_id_exe_en   = 1'b0;
            w_state_nxt     = PC_ST_LU_STALL;
        end
    end

    always_ff @(posedge pci_clk) begin
        if (pci_rst) begin
            r_state <= PC_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic [15:0] r_struct_cnt;

    always_ff @(posedge pci_clk) begin
        if (pci_rst) begin
            r_stall_cnt  <= 16'h0;
            r_flush_cnt  <= 16'h0;
            r_struct_cnt <= 16'h0;
        end else begin
            if (w_ev_lu && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_ev_br && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
            if (w_ev_st && (r_struct_cnt != 16'hFFFF)) begin
                r_struct_cnt <= r_struct_cnt + 16'd1;
            end
        end
    end

    assign pco_stall_cnt  = r_stall_cnt;
    assign pco_flush_cnt  = r_flush_cnt;
    assign pco_struct_cnt = r_struct_cnt;
`else
    assign pco_stall_cnt  = 16'h0;
    assign pco_flush_cnt  = 16'h0;
    assign pco_struct_cnt = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    // Output vector order: {pc_en, pc_sel, if_id_en, if_id_flush, id_exe_en}
    localparam logic [4:0] c_O_RUN = 5'b10101;
    localparam logic [4:0] c_O_BR  = 5'b11110;
    localparam logic [4:0] c_O_ST  = 5'b00111;
    localparam logic [4:0] c_O_LU  = 5'b00000;
    localparam logic [4:0] c_O_RST = 5'b00010;

    logic        clk;
    logic        rst;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  wreg;
    logic [1:0]  exe_rwe;
    logic        branch;
    logic [1:0]  mem_rwe;
    logic        pc_en;
    logic        pc_sel;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_exe_en;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] struct_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall  = 0;
    int exp_flush  = 0;
    int exp_struct = 0;

    pipe_ctrl dut (
        .pci_clk           (clk),
        .pci_rst           (rst),
        .pci_id_rs1        (rs1),
        .pci_id_rs2        (rs2),
        .pci_exe_wreg_addr (wreg),
        .pci_exe_rwe       (exe_rwe),
        .pci_exe_branch    (branch),
        .pci_mem_rwe       (mem_rwe),
        .pco_pc_en         (pc_en),
        .pco_pc_sel        (pc_sel),
        .pco_if_id_en      (if_id_en),
        .pco_if_id_flush   (if_id_flush),
        .pco_id_exe_en     (id_exe_en),
        .pco_stall_cnt     (stall_cnt),
        .pco_flush_cnt     (flush_cnt),
        .pco_struct_cnt    (struct_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counters read 0 unless the perf feature is built in.
    function automatic logic [15:0] expc(input int v);
`ifdef PIPE_CTRL_PERF_EN
        return v[15:0];
`else
        return (v == 0) ? 16'h0 : 16'h0;
`endif
    endfunction

    // Check this cycle's combinational outputs, then advance one clock.
    task automatic cyc(input string tag, input logic [4:0] exp_o);
        #2;
        chk(tag, {27'd0, pc_en, pc_sel, if_id_en, if_id_flush, id_exe_en}, {27'd0, exp_o});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall"},  {16'd0, stall_cnt},  {16'd0, expc(exp_stall)});
        chk({tag, "_flush"},  {16'd0, flush_cnt},  {16'd0, expc(exp_flush)});
        chk({tag, "_struct"}, {16'd0, struct_cnt}, {16'd0, expc(exp_struct)});
    endtask

    task automatic idle();
        rs1 = 4'h1; rs2 = 4'h2; wreg = 4'h5;
        exe_rwe = RWE_IDLE; branch = 1'b0; mem_rwe = RWE_IDLE;
    endtask

    task automatic set_lu();
        rs1 = 4'h3; rs2 = 4'h2; wreg = 4'h3;
        exe_rwe = RWE_READ; branch = 1'b0; mem_rwe = RWE_IDLE;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        cyc("rst_out", c_O_RST);
        chk_cnt("rst_cnt");
        rst = 1'b0;
        cyc("first_run", c_O_RUN);

        // Load-use: one stall cycle, then RUN with unchanged inputs
        set_lu();
        cyc("lu_stall", c_O_LU);      exp_stall++;
        cyc("lu_ignored", c_O_RUN);
        cyc("lu_again", c_O_LU);      exp_stall++;
        idle();
        cyc("lu_release", c_O_RUN);
        chk_cnt("lu_cnt");

        // Branch beats load-use; BR_FLUSH re-evaluates lu
        set_lu(); branch = 1'b1;
        cyc("br_lu", c_O_BR);         exp_flush++;
        chk_cnt("br_cnt");
        branch = 1'b0;
        cyc("brflush_lu", c_O_LU);    exp_stall++;
        mem_rwe = RWE_READ;
        cyc("lustall_st", c_O_ST);    exp_struct++;
        idle(); branch = 1'b1;
        cyc("ststall_br", c_O_BR);    exp_flush++;
        idle();
        cyc("br_release", c_O_RUN);
        chk_cnt("mix_cnt");

        // Structural stall for three consecutive MEM writes
        rst = 1'b1; exp_stall = 0; exp_flush = 0; exp_struct = 0;
        cyc("rst2", c_O_RST);
        rst = 1'b0;
        mem_rwe = RWE_WRITE;
        cyc("st_1", c_O_ST);
        set_lu(); mem_rwe = RWE_WRITE;
        cyc("st_2_over_lu", c_O_ST);
        idle(); mem_rwe = RWE_WRITE;
        cyc("st_3", c_O_ST);          exp_struct = 3;
        idle();
        cyc("st_release", c_O_RUN);
        chk_cnt("st_cnt");

        // Non-hazards: invalid register, write op, idle op; rs2 match stalls
        wreg = REG_INVALID; rs2 = REG_INVALID; rs1 = 4'h4; exe_rwe = RWE_READ;
        cyc("invalid_reg", c_O_RUN);
        wreg = 4'h7; rs1 = 4'h7; exe_rwe = RWE_WRITE;
        cyc("write_no_lu", c_O_RUN);
        exe_rwe = RWE_IDLE;
        cyc("idle_no_lu", c_O_RUN);
        rs1 = 4'h0; rs2 = 4'h7; exe_rwe = RWE_READ;
        cyc("rs2_lu", c_O_LU);        exp_stall++;

        // Reset while in LU_STALL
        set_lu(); rst = 1'b1;
        cyc("rst_mid_stall", c_O_RST);
        exp_stall = 0; exp_flush = 0; exp_struct = 0;
        chk_cnt("rst_mid_cnt");
        rst = 1'b0; idle();
        cyc("after_rst_run", c_O_RUN);
        set_lu();
        cyc("after_rst_lu", c_O_LU);  exp_stall++;
        idle();
        cyc("after_rst_idle", c_O_RUN);
        chk_cnt("after_rst_cnt");

        // Saturation: constant lu inputs give one lu event every two cycles
        rst = 1'b1;
        cyc("rst3", c_O_RST);
        rst = 1'b0;
        set_lu();
`ifdef PIPE_CTRL_PERF_EN
        for (int i = 0; i < 65540 * 2; i++) begin
            @(posedge clk);
        end
        #1;
        chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
`else
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
        end
        #1;
        chk("stall_off", {16'd0, stall_cnt}, 32'h0);
`endif
        chk("flush_zero", {16'd0, flush_cnt}, 32'h0);
        chk("struct_zero", {16'd0, struct_cnt}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
